// File: rtl/fibonacci_checker_if.sv
// Stream interface between a Fibonacci sample source and fibonacci_checker.
//   clear     : synchronous soft clear (source -> checker)
//   in_valid  : fib_in carries a sample this cycle
//   fib_in    : sample value
//   locked    : LOCK_N+ consecutive matches since last error/restart
//   err_pulse : one-cycle pulse, last accepted sample failed a check
//   err_count : saturating count of failed checks
//   expected  : prediction for the next sample (0 outside TRACK/LOCK)
interface fibonacci_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] fib_in;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  modport master (output clear, in_valid, fib_in,
                  input  locked, err_pulse, err_count, expected);
  modport slave  (input  clear, in_valid, fib_in,
                  output locked, err_pulse, err_count, expected);
endinterface

// File: rtl/fibonacci_checker.sv
// Fibonacci stream monitor: checks F(n) = F(n-1) + F(n-2) mod 2^WIDTH
// sample by sample, reports lock, per-sample error pulses and a saturating
// error count.
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   s   : slave side of fibonacci_checker_if (samples in, status out)
module fibonacci_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_N     = 4,   // 1..15
  parameter int CNT_W      = 8,
  parameter int CHECK_SEED = 0
) (
  input  logic clk,
  input  logic rst,
  fibonacci_checker_if.slave s
);

  typedef enum logic [1:0] {EMPTY, ONE, TRACK, LOCK} state_t;

  localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev, curr, last_raw;
  logic [WIDTH-1:0] prev_nxt, curr_nxt, last_raw_nxt;
  logic             miss_run, miss_nxt;
  logic [3:0]       match_run, match_nxt, mr_inc;
  logic             locked_q, locked_nxt;
  logic             err_pulse_q, err_pulse_nxt;
  logic [CNT_W-1:0] err_count_q, err_count_nxt;
  logic [WIDTH-1:0] expected_q, expected_nxt;
  logic [WIDTH-1:0] pred;
  logic             hit, err;

  // carry dropped: arithmetic is modulo 2^WIDTH
  assign pred   = prev + curr;
  assign hit    = (s.fib_in == pred);
  assign mr_inc = (match_run == LOCK_V) ? match_run : match_run + 4'd1;

  // state register (plus datapath and registered outputs)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      prev        <= '0;
      curr        <= '0;
      last_raw    <= '0;
      miss_run    <= 1'b0;
      match_run   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      expected_q  <= '0;
    end else begin
      state       <= state_nxt;
      prev        <= prev_nxt;
      curr        <= curr_nxt;
      last_raw    <= last_raw_nxt;
      miss_run    <= miss_nxt;
      match_run   <= match_nxt;
      locked_q    <= locked_nxt;
      err_pulse_q <= err_pulse_nxt;
      err_count_q <= err_count_nxt;
      expected_q  <= expected_nxt;
    end
  end

  // next-state logic; clear wins over a same-cycle sample
  always_comb begin
    state_nxt = state;
    if (s.clear) begin
      state_nxt = EMPTY;
    end else if (s.in_valid) begin
      case (state)
        EMPTY:   state_nxt = ONE;
        ONE:     state_nxt = TRACK;
        default: state_nxt = (hit && mr_inc == LOCK_V) ? LOCK : TRACK;
      endcase
    end
  end

  // datapath and registered-output next values
  always_comb begin
    prev_nxt      = prev;
    curr_nxt      = curr;
    last_raw_nxt  = last_raw;
    miss_nxt      = miss_run;
    match_nxt     = match_run;
    locked_nxt    = locked_q;
    expected_nxt  = expected_q;
    err           = 1'b0;
    err_pulse_nxt = 1'b0;
    err_count_nxt = err_count_q;
    if (s.clear) begin
      prev_nxt      = '0;
      curr_nxt      = '0;
      last_raw_nxt  = '0;
      miss_nxt      = 1'b0;
      match_nxt     = '0;
      locked_nxt    = 1'b0;
      expected_nxt  = '0;
      err_count_nxt = '0;
    end else if (s.in_valid) begin
      last_raw_nxt = s.fib_in;
      case (state)
        EMPTY: begin
          curr_nxt     = s.fib_in;
          expected_nxt = '0;
          err          = (CHECK_SEED != 0) && (s.fib_in != '0);
        end
        ONE: begin
          prev_nxt     = curr;
          curr_nxt     = s.fib_in;
          expected_nxt = curr + s.fib_in;
          err          = (CHECK_SEED != 0) && (s.fib_in != WIDTH'(1));
        end
        default: begin
          if (hit) begin
            prev_nxt     = curr;
            curr_nxt     = pred;
            miss_nxt     = 1'b0;
            match_nxt    = mr_inc;
            locked_nxt   = (mr_inc == LOCK_V);
            expected_nxt = curr + pred;
          end else if (!miss_run) begin
            // substitute the prediction: one bad sample costs one error
            prev_nxt     = curr;
            curr_nxt     = pred;
            miss_nxt     = 1'b1;
            match_nxt    = '0;
            locked_nxt   = 1'b0;
            expected_nxt = curr + pred;
            err          = 1'b1;
          end else begin
            // two misses in a row: assume generator restart, resync from raw
            prev_nxt     = last_raw;
            curr_nxt     = s.fib_in;
            miss_nxt     = 1'b0;
            match_nxt    = '0;
            locked_nxt   = 1'b0;
            expected_nxt = last_raw + s.fib_in;
            err          = 1'b1;
          end
        end
      endcase
      err_pulse_nxt = err;
      if (err && err_count_q != CNT_MAX) err_count_nxt = err_count_q + 1'b1;
    end
  end

  assign s.locked    = locked_q;
  assign s.err_pulse = err_pulse_q;
  assign s.err_count = err_count_q;
  assign s.expected  = expected_q;

endmodule
